// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the BCD digit width.
package bcd_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble add-3 correction for a single BCD digit.
// din: current digit, dout: digit + 3 when din >= 5, else din.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] din,
   output logic [BCD_W-1:0] dout
);

   assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per cycle.
// In: iCLK, iRST_N, iData/iValid, iReady. Out: oReady, oDigits, oBlank, oNeg, oOverflow, oValid.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DIGITS = 10,
   parameter bit SIGNED = 1'b0
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic [DATA_W-1:0]       iData,
   input  logic                    iValid,
   output logic                    oReady,
   output logic [BCD_W*DIGITS-1:0] oDigits,
   output logic [DIGITS-1:0]       oBlank,
   output logic                    oNeg,
   output logic                    oOverflow,
   output logic                    oValid,
   input  logic                    iReady
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam int BW = BCD_W * DIGITS;
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] op;
   logic [BW-1:0]     dig;
   logic [BW-1:0]     adj;
   logic [BW-1:0]     nxt;
   logic [DIGITS-1:0] blank;
   logic [DIGITS-1:0] nblank;
   logic              neg;
   logic              ovf;
   logic              z;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_adj
         bcd_digit_adj u_adj (
            .din  (dig[k*BCD_W +: BCD_W]),
            .dout (adj[k*BCD_W +: BCD_W])
         );
      end
   endgenerate

   // Corrected chain shifted left, operand MSB enters the ones digit.
   assign nxt = {adj[BW-2:0], op[DATA_W-1]};

   // Leading-zero mask of the digit chain about to be registered.
   always_comb begin
      nblank = '0;
      z      = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         z         = z & (nxt[k*BCD_W +: BCD_W] == '0);
         nblank[k] = z;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state <= IDLE;
         cnt   <= '0;
         op    <= '0;
         dig   <= '0;
         blank <= BLANK_RST;
         neg   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (iValid) begin
                  // Two's-complement magnitude; the most negative value
                  // maps onto itself, which reads as 2^(DATA_W-1) unsigned.
                  op    <= (SIGNED && iData[DATA_W-1]) ?
                           (~iData + DATA_W'(1)) : iData;
                  neg   <= SIGNED & iData[DATA_W-1];
                  dig   <= '0;
                  blank <= BLANK_RST;
                  ovf   <= 1'b0;
                  cnt   <= CW'(DATA_W);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               dig   <= nxt;
               blank <= nblank;
               ovf   <= ovf | adj[BW-1];
               op    <= op << 1;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               if (iReady) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign oReady    = (state == IDLE);
   assign oValid    = (state == DONE);
   assign oDigits   = dig;
   assign oBlank    = blank;
   assign oNeg      = neg;
   assign oOverflow = ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed scoreboard bench for bin2bcd_seq.
// Three instances: defaults, DIGITS=6, SIGNED=1.
module tb_bin2bcd_seq;

   typedef struct {
      logic [39:0] dig;
      logic [9:0]  blank;
      logic        neg;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] dat;
   logic [2:0]  vld;
   logic        rdy;

   logic [39:0] d0;
   logic [23:0] d1;
   logic [39:0] d2;
   logic [9:0]  b0;
   logic [5:0]  b1;
   logic [9:0]  b2;
   logic [2:0]  rdy_o, vld_o, neg_o, ovf_o;

   int          sel;
   logic [39:0] o_dig;
   logic [9:0]  o_blank;
   logic        o_rdy, o_vld, o_neg, o_ovf;

   exp_t        sb[$];
   int          npass;
   int          ntot;

   bin2bcd_seq u0 (
      .iCLK(clk), .iRST_N(rst_n), .iData(dat), .iValid(vld[0]),
      .oReady(rdy_o[0]), .oDigits(d0), .oBlank(b0), .oNeg(neg_o[0]),
      .oOverflow(ovf_o[0]), .oValid(vld_o[0]), .iReady(rdy)
   );

   bin2bcd_seq #(.DIGITS(6)) u1 (
      .iCLK(clk), .iRST_N(rst_n), .iData(dat), .iValid(vld[1]),
      .oReady(rdy_o[1]), .oDigits(d1), .oBlank(b1), .oNeg(neg_o[1]),
      .oOverflow(ovf_o[1]), .oValid(vld_o[1]), .iReady(rdy)
   );

   bin2bcd_seq #(.SIGNED(1'b1)) u2 (
      .iCLK(clk), .iRST_N(rst_n), .iData(dat), .iValid(vld[2]),
      .oReady(rdy_o[2]), .oDigits(d2), .oBlank(b2), .oNeg(neg_o[2]),
      .oOverflow(ovf_o[2]), .oValid(vld_o[2]), .iReady(rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      o_dig   = d0;
      o_blank = b0;
      case (sel)
         1: begin
            o_dig   = {16'b0, d1};
            o_blank = {4'b0, b1};
         end
         2: begin
            o_dig   = d2;
            o_blank = b2;
         end
         default: ;
      endcase
      o_rdy = rdy_o[sel];
      o_vld = vld_o[sel];
      o_neg = neg_o[sel];
      o_ovf = ovf_o[sel];
   end

   function automatic exp_t model(input int inst, input logic [31:0] d);
      exp_t e;
      logic [31:0] m32;
      longint unsigned mag;
      int nd;
      logic zz;
      nd      = (inst == 1) ? 6 : 10;
      e.dig   = '0;
      e.blank = '0;
      e.neg   = (inst == 2) && d[31];
      m32     = e.neg ? (~d + 32'd1) : d;
      mag     = {32'b0, m32};
      for (int k = 0; k < nd; k++) begin
         e.dig[4*k +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
      e.ovf = (mag != 0);
      zz = 1'b1;
      for (int k = nd - 1; k > 0; k--) begin
         zz = zz & (e.dig[4*k +: 4] == 4'd0);
         e.blank[k] = zz;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int inst, input logic [31:0] d);
      sel = inst;
      dat = d;
      vld = '0;
      vld[inst] = 1'b1;
      sb.push_back(model(inst, d));
      #0;
      chk("ready_idle", 64'(o_rdy), 64'd1);
      tick();
      vld = '0;
      chk("busy_after_accept", 64'(o_rdy), 64'd0);
   endtask

   task automatic wait_result(input string tag);
      int lat;
      exp_t e;
      lat = 0;
      while (!o_vld && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd32);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_digits"}, 64'(o_dig), 64'(e.dig));
         chk({tag, "_blank"}, 64'(o_blank), 64'(e.blank));
         chk({tag, "_neg"}, 64'(o_neg), 64'(e.neg));
         chk({tag, "_ovf"}, 64'(o_ovf), 64'(e.ovf));
      end
   endtask

   task automatic release_out(input string tag);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      chk({tag, "_rel_ready"}, 64'(o_rdy), 64'd1);
      chk({tag, "_rel_valid"}, 64'(o_vld), 64'd0);
   endtask

   task automatic conv(input string tag, input int inst,
                       input logic [31:0] d);
      start(inst, d);
      wait_result(tag);
      release_out(tag);
   endtask

   initial begin
      exp_t e42;
      exp_t e;
      npass = 0;
      ntot  = 0;
      sel   = 0;
      rst_n = 1'b0;
      dat   = '0;
      vld   = '0;
      rdy   = 1'b0;
      tick();
      tick();
      chk("rst_digits", 64'(d0), 64'd0);
      chk("rst_blank", 64'(b0), 64'b1111111110);
      chk("rst_blank6", 64'(b1), 64'b111110);
      chk("rst_ready", 64'(rdy_o), 64'b111);
      chk("rst_valid", 64'(vld_o), 64'b000);
      chk("rst_neg_ovf", 64'({neg_o, ovf_o}), 64'd0);
      rst_n = 1'b1;
      tick();

      conv("c123456789", 0, 32'd123456789);
      chk("lit_123456789", 64'(d0), 64'h0123456789);
      conv("cmax", 0, 32'hFFFF_FFFF);
      chk("lit_max", 64'(d0), 64'h4294967295);
      conv("czero", 0, 32'd0);
      chk("lit_zero_blank", 64'(b0), 64'b1111111110);
      conv("c6ovf", 1, 32'd1000000);
      chk("lit_6ovf", 64'({ovf_o[1], d1}), {39'b0, 1'b1, 24'h000000});
      conv("c6ok", 1, 32'd999999);
      conv("sneg1", 2, 32'hFFFF_FFFF);
      chk("lit_sneg1", 64'({neg_o[2], d2}), {23'b0, 1'b1, 40'h1});
      conv("smin", 2, 32'h8000_0000);
      chk("lit_smin", 64'(d2), 64'h2147483648);
      conv("spos", 2, 32'd12345);
      for (int i = 0; i < 4; i++) begin
         conv("rand", 0, $urandom);
      end

      // Hold result in DONE with iReady low; a new iValid must be ignored.
      e42 = model(0, 32'd42);
      start(0, 32'd42);
      wait_result("stall");
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            dat    = 32'd777;
            vld[0] = 1'b1;
         end
         if (i == 8) vld = '0;
         tick();
         chk("stall_digits", 64'(d0), 64'(e42.dig));
         chk("stall_ready", 64'(rdy_o[0]), 64'd0);
         chk("stall_valid", 64'(vld_o[0]), 64'd1);
      end
      release_out("stall");
      repeat (3) tick();
      chk("ignored_valid", 64'(vld_o[0]), 64'd0);
      chk("ignored_digits", 64'(d0), 64'(e42.dig));

      // Reset lands on the tenth shift edge.
      start(0, 32'd99999);
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      e = sb.pop_back();
      chk("abort_valid", 64'(vld_o[0]), 64'd0);
      chk("abort_digits", 64'(d0), 64'd0);
      chk("abort_ready", 64'(rdy_o[0]), 64'd1);
      chk("abort_blank", 64'(b0), 64'b1111111110);
      repeat (40) tick();
      chk("abort_no_result", 64'(vld_o[0]), 64'd0);
      conv("after_abort", 0, 32'd7654321);
      chk("lit_7654321", 64'(d0), 64'h0007654321);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
